// File: rtl/rs_div_pkg.sv
// ============================================================================
// Module      : rs_div_pkg
// Description : Shared types and constants for the sequential restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rs_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int c_MAX_WIDTH = 64;

    // Sliced down to the instance width by the divider.
    localparam logic [c_MAX_WIDTH-1:0] c_DBZ_QUOTIENT = '1;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rs_div_step.sv
// ============================================================================
// Module      : rs_div_step
// Description : One combinational restoring-division iteration (shift, trial
//               subtract, restore).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_q_msb,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q_bit
);

    logic [WIDTH:0]   w_shifted;
    logic [WIDTH+1:0] w_sum;

    assign w_shifted = {i_rem, i_q_msb};

    // Subtract as add of the inverted divisor plus carry-in; carry-out set means no borrow.
    assign w_sum = {1'b0, w_shifted} + {1'b0, ~{1'b0, i_div}} + {{(WIDTH+1){1'b0}}, 1'b1};

    // A successful trial result is always below the divisor, so bit WIDTH is zero then.
    assign o_q_bit = w_sum[WIDTH+1] & ~w_sum[WIDTH];
    assign o_rem   = o_q_bit ? w_sum[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/rs_seq_divider.sv
// ============================================================================
// Module      : rs_seq_divider
// Description : Iterative restoring divider, one quotient bit per clock, with
//               start/busy/done handshake. Define RS_DIV_SIGNED_EN for
//               two's-complement operands.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_seq_divider
    import rs_div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int c_CNT_W = clog2(WIDTH);

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_d;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_dbz;

    logic               w_accept;
    logic               w_div_zero;
    logic               w_last;
    logic [WIDTH-1:0]   w_step_rem;
    logic               w_step_bit;
    logic [WIDTH-1:0]   w_q_shift;
    logic [WIDTH-1:0]   w_dividend_mag;
    logic [WIDTH-1:0]   w_divisor_mag;
    logic [WIDTH-1:0]   w_quot_final;
    logic [WIDTH-1:0]   w_rem_final;

    assign w_accept   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_div_zero = (divisor == '0);
    assign w_last     = (r_cnt == '0);
    assign w_q_shift  = {r_q[WIDTH-2:0], w_step_bit};

    rs_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem   (r_rem),
        .i_q_msb (r_q[WIDTH-1]),
        .i_div   (r_d),
        .o_rem   (w_step_rem),
        .o_q_bit (w_step_bit)
    );

`ifdef RS_DIV_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    assign w_dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign w_divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
    // MIN/-1 needs no special case: |MIN| reads as an unsigned magnitude.
    assign w_quot_final   = r_neg_q ? -w_q_shift  : w_q_shift;
    assign w_rem_final    = r_neg_r ? -w_step_rem : w_step_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_r <= dividend[WIDTH-1];
        end
    end
`else
    assign w_dividend_mag = dividend;
    assign w_divisor_mag  = divisor;
    assign w_quot_final   = w_q_shift;
    assign w_rem_final    = w_step_rem;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = w_div_zero ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_state_next = w_div_zero ? ST_DONE : ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem       <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else if (w_accept) begin
            if (w_div_zero) begin
                r_quotient  <= c_DBZ_QUOTIENT[WIDTH-1:0];
                r_remainder <= dividend;
                r_dbz       <= 1'b1;
            end else begin
                r_rem <= '0;
                r_q   <= w_dividend_mag;
                r_d   <= w_divisor_mag;
                r_cnt <= c_CNT_W'(WIDTH - 1);
            end
        end else if (r_state == ST_RUN) begin
            r_rem <= w_step_rem;
            r_q   <= w_q_shift;
            r_cnt <= r_cnt - c_CNT_W'(1);
            if (w_last) begin
                r_quotient  <= w_quot_final;
                r_remainder <= w_rem_final;
                r_dbz       <= 1'b0;
            end
        end
    end

    assign busy        = (r_state == ST_RUN);
    assign done        = (r_state == ST_DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_rs_seq_divider.sv
// ============================================================================
// Module      : tb_rs_seq_divider
// Description : Directed self-checking bench for rs_seq_divider (WIDTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rs_seq_divider;

    localparam int c_W = 16;

    logic           clk;
    logic           rst;
    logic           start;
    logic [c_W-1:0] dividend;
    logic [c_W-1:0] divisor;
    logic           busy;
    logic           done;
    logic [c_W-1:0] quotient;
    logic [c_W-1:0] remainder;
    logic           div_by_zero;

    int checks;
    int failures;

    rs_seq_divider #(
        .WIDTH (c_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic run_start(input logic [c_W-1:0] dd, input logic [c_W-1:0] dv);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    // Starts an operation and waits (bounded) for done; checks latency and results.
    task automatic do_op(input string tag, input logic [c_W-1:0] dd, input logic [c_W-1:0] dv,
                         input logic [c_W-1:0] eq, input logic [c_W-1:0] er);
        int n;
        run_start(dd, dv);
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(c_W + 1));
        check({tag, "_quot"}, 64'(quotient), 64'(eq));
        check({tag, "_rem"}, 64'(remainder), 64'(er));
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(0));
        step();
    endtask

    initial begin
        int busy_bad;
        int done_seen;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        step();
        step();
        rst = 1'b0;

        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_quot", 64'(quotient), 64'(0));
        check("rst_rem", 64'(remainder), 64'(0));
        check("rst_dbz", 64'(div_by_zero), 64'(0));

        // 100/7: busy for cycles 1..16, done in cycle 17
        run_start(16'd100, 16'd7);
        busy_bad = 0;
        for (int c = 1; c <= 16; c++) begin
            if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
            if (c < 16) step();
        end
        check("t1_busy_window", 64'(busy_bad), 64'(0));
        step();
        check("t1_done", 64'(done), 64'(1));
        check("t1_busy_off", 64'(busy), 64'(0));
        check("t1_quot", 64'(quotient), 64'(14));
        check("t1_rem", 64'(remainder), 64'(2));
        check("t1_dbz", 64'(div_by_zero), 64'(0));
        step();
        check("t1_done_pulse", 64'(done), 64'(0));
        check("t1_hold_quot", 64'(quotient), 64'(14));

        // divide by zero
        run_start(16'h1234, 16'h0000);
        check("dbz_done", 64'(done), 64'(1));
        check("dbz_busy", 64'(busy), 64'(0));
        check("dbz_quot", 64'(quotient), 64'(16'hFFFF));
        check("dbz_rem", 64'(remainder), 64'(16'h1234));
        check("dbz_flag", 64'(div_by_zero), 64'(1));
        step();
        check("dbz_done_pulse", 64'(done), 64'(0));
        check("dbz_busy_after", 64'(busy), 64'(0));
        check("dbz_hold_flag", 64'(div_by_zero), 64'(1));

        // 5/9 with an ignored start in cycle 8
        run_start(16'd5, 16'd9);
        for (int c = 1; c < 8; c++) step();
        dividend = 16'd9;
        divisor  = 16'd3;
        start    = 1'b1;
        step();
        start    = 1'b0;
        check("t3_busy_c9", 64'(busy), 64'(1));
        for (int c = 9; c < 17; c++) step();
        check("t3_done", 64'(done), 64'(1));
        check("t3_quot", 64'(quotient), 64'(0));
        check("t3_rem", 64'(remainder), 64'(5));
        check("t3_dbz_clear", 64'(div_by_zero), 64'(0));
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        check("t3_no_second_op", 64'(done_seen), 64'(0));

        // back-to-back: 65535/1 then 65535/65535 started in the done cycle
        run_start(16'hFFFF, 16'd1);
        for (int c = 1; c < 17; c++) step();
        check("b2b_done1", 64'(done), 64'(1));
        check("b2b_quot1", 64'(quotient), 64'(16'hFFFF));
        check("b2b_rem1", 64'(remainder), 64'(0));
        run_start(16'hFFFF, 16'hFFFF);
        check("b2b_busy2", 64'(busy), 64'(1));
        check("b2b_hold_quot", 64'(quotient), 64'(16'hFFFF));
        for (int c = 1; c < 17; c++) step();
        check("b2b_done2", 64'(done), 64'(1));
        check("b2b_quot2", 64'(quotient), 64'(1));
        check("b2b_rem2", 64'(remainder), 64'(0));
        step();

        // reset in cycle 6 of 200/3
        run_start(16'd200, 16'd3);
        for (int c = 1; c < 6; c++) step();
        rst = 1'b1;
        step();
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_quot", 64'(quotient), 64'(0));
        check("abort_rem", 64'(remainder), 64'(0));
        check("abort_dbz", 64'(div_by_zero), 64'(0));
        rst = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 25; c++) begin
            step();
            if (done === 1'b1) done_seen++;
        end
        check("abort_no_done", 64'(done_seen), 64'(0));

        do_op("u_ff_100", 16'hFFFF, 16'h0100, 16'h00FF, 16'h00FF);
        do_op("u_50000_7", 16'd50000, 16'd7, 16'd7142, 16'd6);
        do_op("u_eq", 16'd1234, 16'd1234, 16'd1, 16'd0);

`ifdef RS_DIV_SIGNED_EN
        do_op("s_m7_2", 16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF);
        do_op("s_7_m2", 16'd7, 16'hFFFE, 16'hFFFD, 16'd1);
        do_op("s_min_m1", 16'h8000, 16'hFFFF, 16'h8000, 16'd0);
`else
        do_op("u_fff9_2", 16'hFFF9, 16'd2, 16'd32764, 16'd1);
        do_op("u_7_fffe", 16'd7, 16'hFFFE, 16'd0, 16'd7);
        do_op("u_8000_ffff", 16'h8000, 16'hFFFF, 16'd0, 16'h8000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
